// File: rtl/conv_window_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : conv_window_controller_pkg
// Purpose : Definitions shared by the convolution window controller and its
//           address generator: the FSM state encoding and a width helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package conv_window_controller_pkg;

    // Controller FSM states. The width is fixed so the encoding stays stable
    // across tools and is easy to recognise in waveforms.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_CALC  = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Bits needed to hold values 0..value-1. Never returns less than 1, so a
    // degenerate dimension still gets a legal vector width.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage : conv_window_controller_pkg
`default_nettype wire

// File: rtl/conv_window_controller_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : conv_window_controller_addr_gen
// Purpose : Window/tap position counters for the convolution controller.
//           Tracks the window origin (row, col) and the tap inside the
//           window (ky, kx, linear tap index). Produces the RAM read address
//           of the current tap.
// Ports   : clk, reset      - clock, synchronous active-high reset
//           i_clear         - return every counter to zero (new pass)
//           i_step          - advance one tap (kx fastest, wraps after last)
//           i_advance       - move to the next window origin, raster order;
//                             wraps to (0,0) after the last window
//           o_addr          - (row+ky)*IMG_W + (col+kx)
//           o_tap           - ky*K + kx
//           o_last_tap      - current tap is K*K-1
//           o_last_window   - current window is the bottom-right one
// Revision: 1.0 - initial release
// ============================================================================
module conv_window_controller_addr_gen
    import conv_window_controller_pkg::*;
#(
    parameter int K          = 3,
    parameter int IMG_W      = 4,
    parameter int IMG_H      = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int TAP_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_step,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [TAP_W-1:0]      o_tap,
    output logic                  o_last_tap,
    output logic                  o_last_window
);

    localparam int KW = clog2_min1(K);
    localparam int RW = clog2_min1(IMG_H);
    localparam int CW = clog2_min1(IMG_W);

    localparam logic [KW-1:0]    C_K_LAST   = KW'(K - 1);
    localparam logic [RW-1:0]    C_ROW_LAST = RW'(IMG_H - K);
    localparam logic [CW-1:0]    C_COL_LAST = CW'(IMG_W - K);
    localparam logic [TAP_W-1:0] C_TAP_LAST = TAP_W'(K * K - 1);

    logic [KW-1:0]    r_kx;
    logic [KW-1:0]    r_ky;
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [TAP_W-1:0] r_tap;

    logic [ADDR_WIDTH-1:0] w_pix_row;
    logic [ADDR_WIDTH-1:0] w_pix_col;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_kx  <= '0;
            r_ky  <= '0;
            r_row <= '0;
            r_col <= '0;
            r_tap <= '0;
        end else begin
            if (i_step) begin
                if (o_last_tap) begin
                    // Window complete: rewind so the next window starts at tap 0.
                    r_kx  <= '0;
                    r_ky  <= '0;
                    r_tap <= '0;
                end else begin
                    r_tap <= r_tap + 1'b1;
                    if (r_kx == C_K_LAST) begin
                        r_kx <= '0;
                        r_ky <= r_ky + 1'b1;
                    end else begin
                        r_kx <= r_kx + 1'b1;
                    end
                end
            end
            if (i_advance) begin
                if (r_col == C_COL_LAST) begin
                    r_col <= '0;
                    if (r_row == C_ROW_LAST) begin
                        r_row <= '0;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign w_pix_row     = ADDR_WIDTH'(r_row) + ADDR_WIDTH'(r_ky);
    assign w_pix_col     = ADDR_WIDTH'(r_col) + ADDR_WIDTH'(r_kx);
    assign o_addr        = w_pix_row * ADDR_WIDTH'(IMG_W) + w_pix_col;
    assign o_tap         = r_tap;
    assign o_last_tap    = (r_tap == C_TAP_LAST);
    assign o_last_window = (r_row == C_ROW_LAST) && (r_col == C_COL_LAST);

endmodule : conv_window_controller_addr_gen
`default_nettype wire

// File: rtl/conv_window_controller.sv
`default_nettype none
// ============================================================================
// Module  : conv_window_controller
// Purpose : Walks every KxK window (stride 1, row-major) of an IMG_W x IMG_H
//           image held in a 1-cycle-latency sync-read RAM, gathers the K*K
//           pixels into a window register feeding an external inner-product
//           unit, registers the IPU sum and offers it on a valid/ready stream.
// Ports   : clk, reset   - clock, synchronous active-high reset
//           start        - begin a pass (only looked at in IDLE)
//           busy         - high outside IDLE
//           done         - one-cycle pulse after the last window is taken
//           mem_rd_en    - RAM read strobe
//           mem_addr     - RAM read address
//           mem_rd_data  - RAM data, valid the cycle after mem_rd_en
//           ipu_data     - window vector, tap i at [D_WIDTH*(i+1)-1:D_WIDTH*i]
//           ipu_result   - combinational IPU sum of ipu_data
//           out_valid / out_ready / out_data - result stream
//           perf_cycles  - busy cycle count of the latest pass
//                          (present only with CONV_CTRL_PERF_EN defined)
// Config  : `define CONV_CTRL_PERF_EN to add the perf_cycles counter/port.
// Revision: 1.0 - initial release
// ============================================================================
module conv_window_controller
    import conv_window_controller_pkg::*;
#(
    parameter int K          = 3,
    parameter int IMG_W      = 4,
    parameter int IMG_H      = 4,
    parameter int D_WIDTH    = 8,
    parameter int Q_WIDTH    = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [D_WIDTH-1:0]     mem_rd_data,
    output logic [D_WIDTH*K*K-1:0] ipu_data,
    input  logic [Q_WIDTH-1:0]     ipu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [Q_WIDTH-1:0]     out_data
`ifdef CONV_CTRL_PERF_EN
    ,
    output logic [31:0]            perf_cycles
`endif
);

    localparam int TAPS  = K * K;
    localparam int TAP_W = clog2_min1(TAPS);

    // Reject geometries the address arithmetic cannot handle.
    if (IMG_W < K || IMG_H < K) begin : g_bad_geometry
        $error("conv_window_controller: image must be at least KxK");
    end
    if ((2.0 ** ADDR_WIDTH) < (IMG_W * IMG_H)) begin : g_bad_addr_width
        $error("conv_window_controller: ADDR_WIDTH too small for image");
    end

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_mem_rd_en;
    logic                  r_out_valid;
    logic [Q_WIDTH-1:0]    r_out_data;

    // Capture pipeline: the RAM answers one cycle after the read, so the
    // tap index and the strobe are delayed by one cycle to pick the slot.
    logic                  r_cap_en;
    logic [TAP_W-1:0]      r_tap_d;
    logic [D_WIDTH-1:0]    r_window [TAPS];

    logic                  w_clear;
    logic                  w_step;
    logic                  w_advance;
    logic                  w_handshake;
    logic [TAP_W-1:0]      w_tap;
    logic                  w_last_tap;
    logic                  w_last_window;

    assign w_handshake = (r_state == S_EMIT) && out_ready;
    assign w_clear     = (r_state == S_IDLE) && start;
    assign w_step      = (r_state == S_FETCH);
    // Advancing from the last window wraps the origin back to (0,0).
    assign w_advance   = w_handshake;

    conv_window_controller_addr_gen #(
        .K          (K),
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TAP_W      (TAP_W)
    ) u_addr_gen (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_clear),
        .i_step        (w_step),
        .i_advance     (w_advance),
        .o_addr        (mem_addr),
        .o_tap         (w_tap),
        .o_last_tap    (w_last_tap),
        .o_last_window (w_last_window)
    );

    // Main sequencer; all status outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_FETCH;
                        r_busy      <= 1'b1;
                        r_mem_rd_en <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (w_last_tap) begin
                        r_state     <= S_WAIT;
                        r_mem_rd_en <= 1'b0;
                    end
                end
                S_WAIT: begin
                    // Last tap lands in the window register this cycle.
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_out_data  <= ipu_result;
                    r_out_valid <= 1'b1;
                    r_state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last_window) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_FETCH;
                            r_mem_rd_en <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_mem_rd_en <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Window register: slots are simply overwritten window after window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap_en <= 1'b0;
            r_tap_d  <= '0;
            for (int i = 0; i < TAPS; i++) begin
                r_window[i] <= '0;
            end
        end else begin
            r_cap_en <= r_mem_rd_en;
            r_tap_d  <= w_tap;
            for (int i = 0; i < TAPS; i++) begin
                if (r_cap_en && (r_tap_d == TAP_W'(i))) begin
                    r_window[i] <= mem_rd_data;
                end
            end
        end
    end

    for (genvar g = 0; g < TAPS; g++) begin : g_pack
        assign ipu_data[D_WIDTH*g +: D_WIDTH] = r_window[g];
    end

`ifdef CONV_CTRL_PERF_EN
    logic [31:0] r_perf_cycles;

    // Counts cycles in which busy is high; restarts when a pass is accepted
    // and naturally holds in IDLE because busy is low there.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_cycles <= '0;
        end else if (w_clear) begin
            r_perf_cycles <= '0;
        end else if (r_busy && (r_perf_cycles != 32'hFFFF_FFFF)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_rd_en = r_mem_rd_en;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule : conv_window_controller
`default_nettype wire
